// File: rtl/alu_sched_pkg.sv
// Shared constants for the two-requester ALU scheduler: state codes,
// default widths and bit positions inside the response flag vector.
package alu_sched_pkg;

  localparam int W_DEF  = 6;
  localparam int FW_DEF = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int FLAG_GT = 2;
  localparam int FLAG_OV = 1;
  localparam int FLAG_CO = 0;

  typedef logic [2:0] rsp_flags_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, a tie goes to the
// requester named by the pointer, and the pointer then moves past the winner.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       ptr_next_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_next_o = ptr_i;
    if (gnt_o[0])
      ptr_next_o = 1'b1;
    else if (gnt_o[1])
      ptr_next_o = 1'b0;
  end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one combinational ALU between two requesters: grants one operation at
// a time, holds it on the ALU for ALU_LAT cycles, then returns the result.
module alu_req_sched
  import alu_sched_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int FW      = FW_DEF,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [FW-1:0]    req0_fxn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [FW-1:0]    req1_fxn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_ans,
  output logic [2:0]       rsp_flags,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [FW-1:0]    alu_fxn,
  input  logic [W-1:0]     alu_ans,
  input  logic             alu_cout,
  input  logic             alu_over_flow,
  input  logic             alu_greater,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  logic [1:0]       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [W-1:0]     a_q, b_q, ans_q;
  logic [FW-1:0]    fxn_q;
  logic             id_q;
  rsp_flags_t       flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LW-1:0]    lat_q;

  logic [1:0] gnt;
  logic       ptr_nxt;
  logic       idle, grant, lat_done;

  rr_arb2 u_arb (
    .req_i      ({req1_valid, req0_valid}),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .ptr_next_o (ptr_nxt)
  );

  assign idle     = (state_q == ST_IDLE);
  assign grant    = idle && (gnt != 2'b00);
  assign lat_done = (lat_q == '0);

  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: if (grant) begin
        state_d = ST_EXEC;
        ptr_d   = ptr_nxt;
      end
      ST_EXEC: if (lat_done) state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand registers double as the ALU drive, so they only change on a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fxn_q   <= '0;
      id_q    <= 1'b0;
      ans_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant) begin
        a_q   <= gnt[1] ? req1_a   : req0_a;
        b_q   <= gnt[1] ? req1_b   : req0_b;
        fxn_q <= gnt[1] ? req1_fxn : req0_fxn;
        id_q  <= gnt[1];
        lat_q <= LW'(ALU_LAT - 1);
      end else if (state_q == ST_EXEC && !lat_done) begin
        lat_q <= lat_q - LW'(1);
      end
      if (state_q == ST_EXEC && lat_done) begin
        ans_q            <= alu_ans;
        flags_q[FLAG_GT] <= alu_greater;
        flags_q[FLAG_OV] <= alu_over_flow;
        flags_q[FLAG_CO] <= alu_cout;
      end
      if (state_q == ST_RESP && rsp_ready)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_fxn   = fxn_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_ans   = ans_q;
  assign rsp_flags = flags_q;
  assign busy      = !idle;
  assign op_count  = cnt_q;

endmodule
